cix32_mem_arbiter: RTL

Two-requester memory arbiter for the CIX-32 core. It shares one unified memory port between the core's instruction-fetch port (imem) and data port (dmem). It sits between the core and a single-ported program/data memory. The block owns the req/ready handshake on both sides and serialises accesses, with one transaction in flight at a time.

---
 rtl/cix32_mem_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/cix32_mem_arbiter.sv
// cix32_mem_arbiter: serialises CIX-32 imem/dmem requests onto one memory port, round-robin on contention.
// Optional watchdog enabled by defining CIX32_ARB_TIMEOUT_EN.
module cix32_mem_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_req,
   output logic [DATA_W-1:0] imem_rdata,
   output logic              imem_ready,
   input  logic [ADDR_W-1:0] dmem_addr,
   input  logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W/8-1:0] dmem_wstrb,
   input  logic              dmem_we,
   input  logic              dmem_req,
   output logic [DATA_W-1:0] dmem_rdata,
   output logic              dmem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   output logic              mem_we,
   output logic              mem_req,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              arb_owner,
   output logic              arb_timeout
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t                state_q, state_d;
   logic                  last_owner_q, last_owner_d;
   logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
   logic [DATA_W/8-1:0]   mem_wstrb_q, mem_wstrb_d;
   logic                  mem_we_q, mem_we_d;
   logic                  mem_req_q, mem_req_d;
   logic                  arb_owner_q, arb_owner_d;
   logic [DATA_W-1:0]     imem_rdata_q, imem_rdata_d;
   logic [DATA_W-1:0]     dmem_rdata_q, dmem_rdata_d;
   logic                  imem_ready_q, imem_ready_d;
   logic                  dmem_ready_q, dmem_ready_d;
   logic                  pick_dmem;
   // dmem wins when alone, or on contention when imem was served last
   assign pick_dmem = dmem_req && (!imem_req || !last_owner_q);
`ifdef CIX32_ARB_TIMEOUT_EN
   logic [31:0] cnt_q, cnt_d;
   logic        arb_timeout_q, arb_timeout_d;
   assign arb_timeout = arb_timeout_q;
`else
   assign arb_timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif
   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_wstrb_d  = mem_wstrb_q;
      mem_we_d     = mem_we_q;
      mem_req_d    = mem_req_q;
      arb_owner_d  = arb_owner_q;
      imem_rdata_d = imem_rdata_q;
      dmem_rdata_d = dmem_rdata_q;
      imem_ready_d = 1'b0;
      dmem_ready_d = 1'b0;
`ifdef CIX32_ARB_TIMEOUT_EN
      cnt_d         = cnt_q;
      arb_timeout_d = 1'b0;
`endif
      case (state_q)
         IDLE: if (imem_req || dmem_req) begin
            mem_addr_d   = pick_dmem ? dmem_addr : imem_addr;
            mem_wdata_d  = pick_dmem ? dmem_wdata : '0;
            mem_wstrb_d  = pick_dmem ? dmem_wstrb : '0;
            mem_we_d     = pick_dmem && dmem_we;
            mem_req_d    = 1'b1;
            arb_owner_d  = pick_dmem;
            last_owner_d = pick_dmem;
            state_d      = BUSY;
`ifdef CIX32_ARB_TIMEOUT_EN
            cnt_d        = '0;
`endif
         end
         BUSY: begin
            if (mem_ready) begin
               mem_req_d    = 1'b0;
               imem_rdata_d = (!arb_owner_q && !mem_we_q) ? mem_rdata : imem_rdata_q;
               dmem_rdata_d = (arb_owner_q && !mem_we_q) ? mem_rdata : dmem_rdata_q;
               imem_ready_d = !arb_owner_q;
               dmem_ready_d = arb_owner_q;
               state_d      = DONE;
            end
`ifdef CIX32_ARB_TIMEOUT_EN
            else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
               mem_req_d     = 1'b0;
               imem_rdata_d  = arb_owner_q ? imem_rdata_q : '1;
               dmem_rdata_d  = arb_owner_q ? '1 : dmem_rdata_q;
               imem_ready_d  = !arb_owner_q;
               dmem_ready_d  = arb_owner_q;
               arb_timeout_d = 1'b1;
               state_d       = DONE;
            end else cnt_d = cnt_q + 32'd1;
`endif
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_owner_q <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_wstrb_q  <= '0;
         mem_we_q     <= 1'b0;
         mem_req_q    <= 1'b0;
         arb_owner_q  <= 1'b0;
         imem_rdata_q <= '0;
         dmem_rdata_q <= '0;
         imem_ready_q <= 1'b0;
         dmem_ready_q <= 1'b0;
`ifdef CIX32_ARB_TIMEOUT_EN
         cnt_q         <= '0;
         arb_timeout_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_wstrb_q  <= mem_wstrb_d;
         mem_we_q     <= mem_we_d;
         mem_req_q    <= mem_req_d;
         arb_owner_q  <= arb_owner_d;
         imem_rdata_q <= imem_rdata_d;
         dmem_rdata_q <= dmem_rdata_d;
         imem_ready_q <= imem_ready_d;
         dmem_ready_q <= dmem_ready_d;
`ifdef CIX32_ARB_TIMEOUT_EN
         cnt_q         <= cnt_d;
         arb_timeout_q <= arb_timeout_d;
`endif
      end
   end
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_wstrb  = mem_wstrb_q;
   assign mem_we     = mem_we_q;
   assign mem_req    = mem_req_q;
   assign arb_owner  = arb_owner_q;
   assign imem_rdata = imem_rdata_q;
   assign dmem_rdata = dmem_rdata_q;
   assign imem_ready = imem_ready_q;
   assign dmem_ready = dmem_ready_q;
endmodule
